// File: rtl/request_encoder_if.sv
// Handshake bundle between a request-vector producer and the request encoder.
// The slave modport is the encoder's view; master is the producer/consumer side.
interface request_encoder_if;
  logic        load_valid;
  logic [15:0] load_vector;
  logic        load_ready;
  logic [3:0]  out_address;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  pending_count;
  logic        done;

  modport slave (
    input  load_valid,
    input  load_vector,
    input  out_ready,
    output load_ready,
    output out_address,
    output out_valid,
    output pending_count,
    output done
  );

  modport master (
    output load_valid,
    output load_vector,
    output out_ready,
    input  load_ready,
    input  out_address,
    input  out_valid,
    input  pending_count,
    input  done
  );
endinterface

// File: rtl/request_encoder.sv
// Drains a 16-line request vector one address per handshake in fixed priority order,
// reporting the remaining popcount and pulsing done once the vector is empty.
module request_encoder #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  request_encoder_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pending_q, pending_d;
  logic        done_q, done_d;
  logic [3:0]  selAddr;
  logic [4:0]  popCount;

  // Priority pick: the last match in scan order wins, so scan away from the favoured end.
  always_comb begin
    selAddr = 4'd0;
    if (LSB_FIRST) begin
      for (int i = 15; i >= 0; i--) begin
        if (pending_q[i]) selAddr = 4'(i);
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (pending_q[i]) selAddr = 4'(i);
      end
    end
  end

  always_comb begin
    popCount = 5'd0;
    for (int i = 0; i < 16; i++) begin
      popCount = popCount + 5'(pending_q[i]);
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load_valid) begin
          if (bus.load_vector != 16'h0000) begin
            pending_d = bus.load_vector;
            state_d   = EMIT;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          pending_d = pending_q & ~(16'h0001 << selAddr);
          if (pending_d == 16'h0000) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = 16'h0000;
      end
    endcase
  end

  // Reset discards any partially drained vector without signalling completion.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pending_q <= 16'h0000;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

  assign bus.load_ready    = (state_q == IDLE);
  assign bus.out_valid     = (state_q == EMIT);
  assign bus.out_address   = (state_q == EMIT) ? selAddr : 4'd0;
  assign bus.pending_count = popCount;
  assign bus.done          = done_q;

endmodule

// File: tb/tb_request_encoder.sv
// Directed-vector bench for request_encoder: drain order, backpressure, ignored loads,
// zero-vector loads and mid-drain reset, all against hand-computed expectations.
module tb_request_encoder;
  localparam bit LSB_FIRST = 1'b1;

  logic clock;
  logic reset;
  int   checkCount;
  int   failCount;

  request_encoder_if bus ();

  request_encoder #(.LSB_FIRST(LSB_FIRST)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [15:0] vector, input logic ready);
    bus.load_valid  = valid;
    bus.load_vector = vector;
    bus.out_ready   = ready;
  endtask

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic checkIdle(input string tag, input logic expDone);
    checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, "_ready"}, 32'(bus.load_ready), 32'd1);
    checkOutput({tag, "_addr"}, 32'(bus.out_address), 32'd0);
    checkOutput({tag, "_count"}, 32'(bus.pending_count), 32'd0);
    checkOutput({tag, "_done"}, 32'(bus.done), 32'(expDone));
  endtask

  task automatic checkEmit(input string tag, input int expAddr, input int expCount);
    checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    checkOutput({tag, "_ready"}, 32'(bus.load_ready), 32'd0);
    checkOutput({tag, "_addr"}, 32'(bus.out_address), 32'(expAddr));
    checkOutput({tag, "_count"}, 32'(bus.pending_count), 32'(expCount));
    checkOutput({tag, "_done"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int addrs8421[4];
    int expAddr;
    checkCount = 0;
    failCount  = 0;
    addrs8421  = '{0, 5, 10, 15};
    if (!LSB_FIRST) addrs8421 = '{15, 10, 5, 0};

    applyStimulus(1'b0, 16'h0000, 1'b0);
    reset = 1'b0;
    #12;
    checkIdle("reset", 1'b0);
    #5 reset = 1'b1;
    stepCycle();
    checkIdle("postReset", 1'b0);

    $display("[TB] 8421 with out_ready held high");
    applyStimulus(1'b1, 16'h8421, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkEmit($sformatf("v8421_%0d", i), addrs8421[i], 4 - i);
      stepCycle();
    end
    checkIdle("v8421_end", 1'b1);
    stepCycle();
    checkIdle("v8421_after", 1'b0);

    $display("[TB] all-zero vector");
    applyStimulus(1'b1, 16'h0000, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkIdle("zero_done", 1'b1);
    stepCycle();
    checkIdle("zero_after", 1'b0);

    $display("[TB] 0030 with backpressure");
    applyStimulus(1'b1, 16'h0030, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkEmit($sformatf("v0030_hold%0d", i), LSB_FIRST ? 4 : 5, 2);
      if (i < 2) stepCycle();
    end
    applyStimulus(1'b0, 16'h0000, 1'b1);
    stepCycle();
    checkEmit("v0030_second", LSB_FIRST ? 5 : 4, 1);
    stepCycle();
    checkIdle("v0030_end", 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b0);
    stepCycle();

    $display("[TB] FFFF full drain");
    applyStimulus(1'b1, 16'hFFFF, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 16; i++) begin
      expAddr = LSB_FIRST ? i : 15 - i;
      checkEmit($sformatf("vFFFF_%0d", i), expAddr, 16 - i);
      stepCycle();
    end
    checkIdle("vFFFF_end", 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b0);
    stepCycle();

    $display("[TB] load offered during EMIT");
    applyStimulus(1'b1, 16'h0300, 1'b0);
    stepCycle();
    checkEmit("v0300_first", LSB_FIRST ? 8 : 9, 2);
    applyStimulus(1'b1, 16'h0001, 1'b0);
    stepCycle();
    checkEmit("v0300_ignored", LSB_FIRST ? 8 : 9, 2);
    applyStimulus(1'b1, 16'h0001, 1'b1);
    stepCycle();
    checkEmit("v0300_second", LSB_FIRST ? 9 : 8, 1);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    stepCycle();
    checkIdle("v0300_end", 1'b1);
    stepCycle();
    checkIdle("v0300_after", 1'b0);

    $display("[TB] reset mid-drain");
    applyStimulus(1'b1, 16'h0007, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkEmit("v0007_first", LSB_FIRST ? 0 : 2, 3);
    stepCycle();
    checkEmit("v0007_second", 1, 2);
    #2 reset = 1'b0;
    #1;
    checkIdle("midReset", 1'b0);
    stepCycle();
    checkIdle("midResetHeld", 1'b0);
    #3 reset = 1'b1;
    stepCycle();
    checkIdle("midResetRelease", 1'b0);
    stepCycle();
    checkIdle("midResetNoDone", 1'b0);

    $display("[TB] load after reset");
    applyStimulus(1'b1, 16'h0002, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkEmit("v0002", 1, 1);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    stepCycle();
    checkIdle("v0002_end", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end
endmodule

// File: doc/request_encoder.md
REQUEST_ENCODER -- requirements
Module: request_encoder

Interface
REQ-001 The block SHALL have parameter LSB_FIRST, default 1: 1 = lowest set index served first, 0 = highest set index served first.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port load_valid, input, 1 bit: load_vector is offered.
REQ-005 The block SHALL have port load_vector, input, 16 bits: one-hot-per-line request vector; bit i requests address i.
REQ-006 The block SHALL have port load_ready, output, 1 bit: block can accept a new vector.
REQ-007 The block SHALL have port out_address, output, 4 bits: encoded address of the current pending line.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_address is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: consumer accepts out_address.
REQ-010 The block SHALL have port pending_count, output, 5 bits: number of set bits still pending (0..16).
REQ-011 The block SHALL have port done, output, 1 bit: single-cycle pulse when a loaded vector is fully drained.

Function
REQ-012 The block SHALL implement a two-state FSM, IDLE and EMIT, with a 16-bit pending register.
REQ-013 In IDLE, load_ready SHALL be 1, out_valid SHALL be 0, and out_address SHALL be 0.
REQ-014 A load SHALL be accepted on a rising edge where load_valid=1 and load_ready=1.
REQ-015 On an accepted nonzero load, pending SHALL be set to load_vector, the FSM SHALL go to EMIT, and out_valid SHALL be 1 in the next cycle (1-cycle latency).
REQ-016 On an accepted all-zero load, the FSM SHALL stay in IDLE and done SHALL pulse for one cycle in the next cycle.
REQ-017 In EMIT, load_ready SHALL be 0, and load_valid SHALL be ignored with no capture and no error.
REQ-018 In EMIT, out_valid SHALL be 1 and out_address SHALL be the index of the lowest set pending bit (LSB_FIRST=1) or the highest set pending bit (LSB_FIRST=0).
REQ-019 out_address SHALL be driven combinationally from registered pending and SHALL remain stable while out_valid=1 and out_ready=0.
REQ-020 On a handshake (out_valid=1 and out_ready=1), the served bit SHALL be cleared from pending at that edge, and the next address SHALL appear in the following cycle with no bubble.
REQ-021 A vector with k set bits SHALL produce exactly k handshakes, each address exactly once, in strict priority order.
REQ-022 pending_count SHALL equal the popcount of pending; it SHALL be 16 for 16'hFFFF and SHALL never wrap.
REQ-023 When the handshake clears the last pending bit, the FSM SHALL return to IDLE.
REQ-024 After the last-bit handshake, done SHALL be 1 for exactly one cycle, coincident with load_ready returning to 1.
REQ-025 A new load SHALL be acceptable in the same cycle that done is 1.
REQ-026 out_ready asserted while out_valid=0 SHALL have no effect.
REQ-027 The block SHALL contain no combinational path from load_valid, load_vector, or out_ready to any output.

Reset
REQ-028 While reset=0, the block SHALL asynchronously force state=IDLE, pending=16'h0000, done=0, out_valid=0, out_address=0, pending_count=0, and load_ready=1.
REQ-029 A reset assertion mid-drain SHALL discard all remaining pending bits and SHALL NOT produce a done pulse.
REQ-030 The first load SHALL be accepted no earlier than the first rising edge after reset deasserts.

Verification
REQ-031 The bench SHALL cover: load 16'h8421 with out_ready=1 constantly -> addresses 0, 5, 10, 15 on four consecutive cycles; pending_count 4, 3, 2, 1; done pulse the cycle after address 15.
REQ-032 The bench SHALL cover: load 16'h0000 -> no out_valid, done=1 for one cycle, load_ready stays 1.
REQ-033 The bench SHALL cover: load 16'h0030 with out_ready=0 for 3 cycles, then 1 -> out_address holds 4 for 3 cycles, then 4 and 5 are each accepted once.
REQ-034 The bench SHALL cover: load 16'hFFFF -> pending_count reads 16; 16 handshakes yield 0..15 in order (15..0 with LSB_FIRST=0).
REQ-035 The bench SHALL cover: load_valid=1 with 16'h0001 during EMIT of 16'h0300 -> ignored; outputs are only 8 and 9.
REQ-036 The bench SHALL cover: reset=0 asserted after the first handshake of 16'h0007 -> out_valid=0 and pending_count=0 immediately, no done pulse, and load_ready=1.
